sum_serial_ctrl: RTL and testbench

Multi-cycle controller that performs WIDTH-bit add/subtract by sequencing one 4-bit adder (sum4b: A, B, Ci → S, Co) nibble by nibble, LSB first.
- Carry is registered between nibbles.
- Operands are latched on a start/done handshake.
- Sits between operand registers and the result/flag display logic of the lab datapath.

---
 rtl/sum_serial_ctrl.sv | 131 +++++++++++++
 tb/tb_sum_serial_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_serial_ctrl.sv
// ============================================================================
// Module   : sum_serial_ctrl (with helper sum4b)
// Purpose  : WIDTH-bit add/subtract sequenced through one 4-bit adder,
//            nibble by nibble, LSB first, with a registered carry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum4b (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [4:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_ci};
    assign o_s     = w_total[3:0];
    assign o_co    = w_total[4];
endmodule

module sum_serial_ctrl #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);
    localparam int c_CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic              r_carry;
    logic [WIDTH-1:0]  r_op_a;
    logic [WIDTH-1:0]  r_op_b;
    logic [WIDTH-1:0]  r_part;

    logic [c_CW+1:0]   w_lsb;
    logic [3:0]        w_sum;
    logic              w_co;
    logic [WIDTH-1:0]  w_result;

    assign w_lsb = {r_cnt, 2'b00};

    sum4b u_adder (
        .i_a  (r_op_a[w_lsb +: 4]),
        .i_b  (r_op_b[w_lsb +: 4]),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // Partial result with the current nibble merged in; on the last nibble
    // this is the complete result, which also keeps WIDTH = 4 free of slices.
    always_comb begin
        w_result             = r_part;
        w_result[w_lsb +: 4] = w_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_part  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction as A + ~B + 1: invert B, seed carry with 1.
                        r_op_a  <= a;
                        r_op_b  <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_part  <= w_result;
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        s       <= w_result;
                        co      <= w_co;
                        ovf     <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                                   (w_sum[3] != r_op_a[WIDTH-1]);
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_sum_serial_ctrl.sv
// ============================================================================
// Module   : tb_sum_serial_ctrl
// Purpose  : Directed self-checking bench for sum_serial_ctrl (WIDTH = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sum_serial_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] s;
    logic        co;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    sum_serial_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait for done; inputs are scrambled after the
    // start edge so the result depends only on the latched operands.
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                          output int lat, output int bcnt, output bit tmo);
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; sub = ~sv;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        tmo  = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h1234; b = 16'h4321;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = ~start;
            checks++;
            if ({busy, done, s, co, ovf} !== 20'd0) begin
                errors++;
                $display("FAIL reset_hold: busy=%b done=%b s=%h co=%b ovf=%b, want all 0",
                         busy, done, s, co, ovf);
            end
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        int lat, bcnt; bit tmo;
        run_op(16'h1234, 16'h4321, 1'b0, lat, bcnt, tmo);
        checks++;
        if (tmo || lat != 4) begin
            errors++;
            $display("FAIL add_latency: got %0d (timeout=%b), want 4", lat, tmo);
        end
        checks++;
        if (bcnt != 5) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d, want 5", bcnt);
        end
        checks++;
        if (s !== 16'h5555 || co !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL add_result: s=%h co=%b ovf=%b, want 5555 0 0", s, co, ovf);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 16'h5555) begin
            errors++;
            $display("FAIL add_after_done: busy=%b done=%b s=%h, want 0 0 5555", busy, done, s);
        end
    endtask

    task automatic test_carry();
        int lat, bcnt; bit tmo;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat, bcnt, tmo);
        checks++;
        if (tmo || s !== 16'h0000 || co !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_ripple: s=%h co=%b ovf=%b tmo=%b, want 0000 1 0", s, co, ovf, tmo);
        end
        run_op(16'h7FFF, 16'h0001, 1'b0, lat, bcnt, tmo);
        checks++;
        if (tmo || s !== 16'h8000 || co !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL add_overflow: s=%h co=%b ovf=%b tmo=%b, want 8000 0 1", s, co, ovf, tmo);
        end
    endtask

    task automatic test_sub();
        int lat, bcnt; bit tmo;
        run_op(16'h0005, 16'h0007, 1'b1, lat, bcnt, tmo);
        checks++;
        if (tmo || s !== 16'hFFFE || co !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: s=%h co=%b ovf=%b tmo=%b, want fffe 0 0", s, co, ovf, tmo);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL sub_latency: got %0d, want 4", lat);
        end
        run_op(16'h8000, 16'h0001, 1'b1, lat, bcnt, tmo);
        checks++;
        if (tmo || s !== 16'h7FFF || co !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sub_overflow: s=%h co=%b ovf=%b tmo=%b, want 7fff 1 1", s, co, ovf, tmo);
        end
        run_op(16'h0009, 16'h0009, 1'b1, lat, bcnt, tmo);
        checks++;
        if (tmo || s !== 16'h0000 || co !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal: s=%h co=%b ovf=%b tmo=%b, want 0000 1 0", s, co, ovf, tmo);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt; bit tmo;
        run_op(16'h00FF, 16'h0F01, 1'b0, lat, bcnt, tmo);
        checks++;
        if (tmo || s !== 16'h1000 || co !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: s=%h co=%b tmo=%b, want 1000 0", s, co, tmo);
        end
        // Next launch lands on the first IDLE edge: one op per 6 cycles.
        run_op(16'hC000, 16'h4000, 1'b0, lat, bcnt, tmo);
        checks++;
        if (tmo || lat != 4 || s !== 16'h0000 || co !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: s=%h co=%b ovf=%b lat=%0d, want 0000 1 0 lat 4",
                     s, co, ovf, lat);
        end
    endtask

    task automatic test_busy_protect();
        int ndone = 0;
        int done_at = -1;
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                done_at = k;
            end
            if (k == 1) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
            end
            if (k == 2) start = 1'b0;
            if (k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
        end
        checks++;
        if (ndone != 1 || done_at != 4) begin
            errors++;
            $display("FAIL busy_done_count: pulses=%0d at=%0d, want 1 at 4", ndone, done_at);
        end
        checks++;
        if (s !== 16'h0003 || co !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_result: s=%h co=%b ovf=%b busy=%b, want 0003 0 0 0", s, co, ovf, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (s !== 16'h0003 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold_idle: s=%h busy=%b done=%b, want 0003 0 0", s, busy, done);
        end
    endtask

    task automatic test_abort();
        int lat, bcnt; bit tmo;
        bit saw_done = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, s, co, ovf} !== 20'd0) begin
            errors++;
            $display("FAIL abort_async: busy=%b done=%b s=%h co=%b ovf=%b, want all 0",
                     busy, done, s, co, ovf);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_no_done: done pulse seen=%b, want 0", saw_done);
        end
        run_op(16'h0100, 16'h0200, 1'b0, lat, bcnt, tmo);
        checks++;
        if (tmo || lat != 4 || s !== 16'h0300 || co !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_recover: s=%h co=%b ovf=%b lat=%0d, want 0300 0 0 lat 4",
                     s, co, ovf, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_back_to_back();
        test_busy_protect();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
